sisc_seq: RTL and testbench
===========================

SISC_SEQ -- requirements
Module: sisc_seq

Interface
REQ-001 The block SHALL be clocked by clk, rising edge only.
REQ-002 The block SHALL use a single clock; reset is rst_f, asynchronous, active-low.
REQ-003 Ports SHALL be:
- clk  in  1  system clock
- rst_f  in  1  async active-low reset
- opcode  in  4  instruction[31:28]
- mm  in  4  instruction[27:24], branch condition mask
- stat  in  4  status register output {C,V,N,Z}
- pc_rst  out  1  clear program counter
- pc_write  out  1  load program counter
- pc_sel  out  1  0 = PC+1, 1 = branch target
- br_sel  out  1  0 = absolute target, 1 = PC-relative target
- ir_load  out  1  latch instruction register
- rb_sel  out  1  0 = read_regb from instruction[15:12], 1 = from instruction[23:20]
- alu_op  out  2  00 = pass/add, 01 = reg-reg func, 10 = reg-imm func, 11 = reserved
- stat_en  out  1  update status register
- dm_we  out  1  data memory write enable
- rf_we  out  1  register file write enable
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  processor stopped
- icount  out  16  retired-instruction counter

Function
REQ-004 The FSM SHALL have states START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, and HALT.
REQ-005 All outputs except icount SHALL be combinational from the current state and opcode (Moore per state, qualified by opcode); any output not listed for a state SHALL be 0.
REQ-006 START SHALL assert pc_rst and go to FETCH on the next edge.
REQ-007 FETCH SHALL assert ir_load, pc_write, and pc_sel=0, and SHALL go to DECODE.
REQ-008 DECODE SHALL assert rb_sel=1 when opcode=4'hC, and SHALL go to HALT when opcode=4'hF, else to EXECUTE.
REQ-009 EXECUTE SHALL behave per opcode:
- 4'h1: alu_op=01, stat_en=1
- 4'h2: alu_op=10, stat_en=1
- 4'h4 (BRA): pc_sel=1, br_sel=0
- 4'h5 (BRR): pc_sel=1, br_sel=1
- 4'h8 / 4'hC: alu_op=00 (address)
- 4'hC: rb_sel=1
REQ-010 For BRA and BRR, pc_write SHALL be 1 in EXECUTE only if (stat & mm) != 4'b0000; mm=4'b0000 SHALL mean never taken.
REQ-011 EXECUTE SHALL go to MEM.
REQ-012 MEM SHALL assert dm_we=1 and rb_sel=1 for opcode 4'hC, and SHALL go to WRITEBACK.
REQ-013 WRITEBACK SHALL assert rf_we=1 for opcodes 4'h1, 4'h2, and 4'h8.
REQ-014 WRITEBACK SHALL assert wb_sel=1 for opcode 4'h8, and SHALL hold alu_op at its EXECUTE value for 4'h1 and 4'h2.
REQ-015 WRITEBACK SHALL go to FETCH.
REQ-016 Every non-halt instruction SHALL take exactly 5 cycles, FETCH through WRITEBACK.
REQ-017 Opcode 4'h0 and all undefined opcodes SHALL execute as NOP: full 5-cycle sequence, no rf_we, dm_we, stat_en, or branch pc_write.
REQ-018 HALT SHALL assert halted=1 with all other control outputs 0, and SHALL remain in HALT until rst_f is asserted.
REQ-019 icount SHALL increment by 1 on the WRITEBACK-to-FETCH edge and on the DECODE-to-HALT edge, and SHALL saturate at 16'hFFFF (no wrap).
REQ-020 Opcode, mm, and stat SHALL be sampled combinationally in the state that uses them; the block SHALL NOT store them.

Reset
REQ-021 When rst_f=0, state SHALL go to START and icount to 0 immediately, without waiting for clk.
REQ-022 During reset all outputs SHALL be 0 except pc_rst=1.
REQ-023 Reset asserted mid-instruction (any state, including HALT) SHALL abort the instruction with no further rf_we or dm_we pulses.
REQ-024 After rst_f deasserts, START SHALL persist until the first clk edge.

Verification
REQ-025 Scenario: reset release, opcode=4'h1 -> states START, FETCH, DECODE, EXECUTE (alu_op=01, stat_en=1), MEM, WRITEBACK (rf_we=1, wb_sel=0); icount=1 after 6 edges.
REQ-026 Scenario: BRA with mm=4'b0001, stat=4'b0001 -> pc_write=1 and pc_sel=1 in EXECUTE; with stat=4'b0010 -> pc_write=0 in EXECUTE.
REQ-027 Scenario: opcode=4'hC -> dm_we=1 only in MEM, rb_sel=1 in DECODE, EXECUTE, and MEM, rf_we never asserted; opcode=4'h8 -> rf_we=1 and wb_sel=1 in WRITEBACK.
REQ-028 Scenario: opcode=4'hF -> halted=1 from the cycle after DECODE, stays high across 100 clocks, icount increments once; rst_f pulse returns the block to START.
REQ-029 Scenario: rst_f dropped mid-cycle during MEM of a store -> dm_we falls immediately, pc_rst=1, icount=0.
REQ-030 Scenario: icount forced to 16'hFFFE, run 3 NOPs -> icount reads 16'hFFFF and holds.

Source files
------------

// File: rtl/sisc_seq.sv
// sisc_seq -- multi-cycle control sequencer for the SISC processor.
//
// Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK
// (five cycles), or parks in HALT on opcode 4'hF until reset. Control outputs
// are decoded combinationally from the current state and the live opcode;
// opcode, mm and stat are never stored here.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_f    in   asynchronous active-low reset
//   opcode   in   [3:0] instruction[31:28]
//   mm       in   [3:0] instruction[27:24], branch condition mask
//   stat     in   [3:0] status register {C,V,N,Z}
//   pc_rst   out  clear program counter
//   pc_write out  load program counter
//   pc_sel   out  0 = PC+1, 1 = branch target
//   br_sel   out  0 = absolute target, 1 = PC-relative target
//   ir_load  out  latch instruction register
//   rb_sel   out  0 = read_regb from instr[15:12], 1 = from instr[23:20]
//   alu_op   out  [1:0] 00 pass/add, 01 reg-reg, 10 reg-imm, 11 reserved
//   stat_en  out  update status register
//   dm_we    out  data memory write enable
//   rf_we    out  register file write enable
//   wb_sel   out  0 = ALU result, 1 = memory data
//   halted   out  processor stopped
//   icount   out  [15:0] retired-instruction counter, saturating
module sisc_seq (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [3:0]  opcode,
  input  logic [3:0]  mm,
  input  logic [3:0]  stat,
  output logic        pc_rst,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        br_sel,
  output logic        ir_load,
  output logic        rb_sel,
  output logic [1:0]  alu_op,
  output logic        stat_en,
  output logic        dm_we,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        halted,
  output logic [15:0] icount
);

  localparam logic [3:0] OP_ALU_RR = 4'h1;
  localparam logic [3:0] OP_ALU_RI = 4'h2;
  localparam logic [3:0] OP_BRA    = 4'h4;
  localparam logic [3:0] OP_BRR    = 4'h5;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    START,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    HALT
  } state_t;

  state_t state;

  // Branch condition: any selected status bit set; mm == 0 never takes.
  logic br_taken;
  assign br_taken = |(stat & mm);

  // An instruction retires on WRITEBACK->FETCH, and a halt retires on
  // DECODE->HALT.
  logic retire;
  assign retire = (state == WRITEBACK) ||
                  ((state == DECODE) && (opcode == OP_HALT));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state  <= START;
      icount <= '0;
    end else begin
      case (state)
        START:     state <= FETCH;
        FETCH:     state <= DECODE;
        DECODE:    state <= (opcode == OP_HALT) ? HALT : EXECUTE;
        EXECUTE:   state <= MEM;
        MEM:       state <= WRITEBACK;
        WRITEBACK: state <= FETCH;
        HALT:      state <= HALT;
        default:   state <= START;
      endcase
      if (retire && (icount != '1)) begin
        icount <= icount + 16'd1;
      end
    end
  end

  always_comb begin
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    rb_sel   = 1'b0;
    alu_op   = 2'b00;
    stat_en  = 1'b0;
    dm_we    = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    halted   = 1'b0;
    case (state)
      START: pc_rst = 1'b1;
      FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        pc_sel   = 1'b0;
      end
      DECODE: rb_sel = (opcode == OP_STORE);
      EXECUTE: begin
        case (opcode)
          OP_ALU_RR: begin
            alu_op  = 2'b01;
            stat_en = 1'b1;
          end
          OP_ALU_RI: begin
            alu_op  = 2'b10;
            stat_en = 1'b1;
          end
          OP_BRA: begin
            pc_sel   = 1'b1;
            br_sel   = 1'b0;
            pc_write = br_taken;
          end
          OP_BRR: begin
            pc_sel   = 1'b1;
            br_sel   = 1'b1;
            pc_write = br_taken;
          end
          OP_LOAD:  alu_op = 2'b00;
          OP_STORE: begin
            alu_op = 2'b00;
            rb_sel = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        if (opcode == OP_STORE) begin
          dm_we  = 1'b1;
          rb_sel = 1'b1;
        end
      end
      WRITEBACK: begin
        case (opcode)
          OP_ALU_RR: begin
            rf_we  = 1'b1;
            alu_op = 2'b01;
          end
          OP_ALU_RI: begin
            rf_we  = 1'b1;
            alu_op = 2'b10;
          end
          OP_LOAD: begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
          end
          default: ;
        endcase
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_seq.sv
// Directed testbench for sisc_seq. Control outputs are packed as
// {pc_rst,pc_write,pc_sel,br_sel,ir_load,rb_sel,alu_op[1:0],stat_en,dm_we,
//  rf_we,wb_sel,halted} and compared against hand-computed constants.
module tb_sisc_seq;

  logic        clk;
  logic        rst_f;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [3:0]  stat;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        ir_load;
  logic        rb_sel;
  logic [1:0]  alu_op;
  logic        stat_en;
  logic        dm_we;
  logic        rf_we;
  logic        wb_sel;
  logic        halted;
  logic [15:0] icount;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [15:0] exp_icnt;

  localparam logic [12:0] C_START = 13'h1000;
  localparam logic [12:0] C_FETCH = 13'h0900;
  localparam logic [12:0] C_IDLE  = 13'h0000;
  localparam logic [12:0] C_RB    = 13'h0080;
  localparam logic [12:0] C_HALT  = 13'h0001;

  logic [12:0] ctl;
  assign ctl = {pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel, alu_op,
                stat_en, dm_we, rf_we, wb_sel, halted};

  sisc_seq dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .ir_load  (ir_load),
    .rb_sel   (rb_sel),
    .alu_op   (alu_op),
    .stat_en  (stat_en),
    .dm_we    (dm_we),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .halted   (halted),
    .icount   (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 5-cycle instruction starting in FETCH, checking each cycle.
  task automatic run_instr(input string name, input logic [3:0] op,
                           input logic [12:0] e_dec, input logic [12:0] e_exe,
                           input logic [12:0] e_mem, input logic [12:0] e_wb);
    logic [12:0] exp_v [5];
    exp_v[0] = C_FETCH;
    exp_v[1] = e_dec;
    exp_v[2] = e_exe;
    exp_v[3] = e_mem;
    exp_v[4] = e_wb;
    opcode = op;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ctl !== exp_v[i]) begin
        n_bad++;
        $display("FAIL %s cycle %0d: ctl got %h want %h", name, i, ctl, exp_v[i]);
      end
      step();
    end
    if (exp_icnt != 16'hFFFF) exp_icnt = exp_icnt + 16'd1;
    n_cmp++;
    if (icount !== exp_icnt) begin
      n_bad++;
      $display("FAIL %s icount: got %h want %h", name, icount, exp_icnt);
    end
  endtask

  // Applies reset asynchronously between edges and releases it to reach FETCH.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst_f = 1'b0;
    #1;
    exp_icnt = '0;
    n_cmp++;
    if (ctl !== C_START || icount !== 16'h0000) begin
      n_bad++;
      $display("FAIL %s async: ctl got %h want %h, icount got %h want 0000",
               name, ctl, C_START, icount);
    end
    step();
    n_cmp++;
    if (ctl !== C_START) begin
      n_bad++;
      $display("FAIL %s held: ctl got %h want %h", name, ctl, C_START);
    end
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_START) begin
      n_bad++;
      $display("FAIL %s start_persist: ctl got %h want %h", name, ctl, C_START);
    end
    step();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (ctl !== C_START || icount !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_init: ctl got %h want %h, icount got %h want 0000",
               ctl, C_START, icount);
    end
    do_reset("reset");
  endtask

  task automatic test_alu();
    run_instr("alu_rr", 4'h1, C_IDLE, 13'h0030, C_IDLE, 13'h0024);
    run_instr("alu_ri", 4'h2, C_IDLE, 13'h0050, C_IDLE, 13'h0044);
  endtask

  task automatic test_branch();
    mm = 4'b0001; stat = 4'b0001;
    run_instr("bra_taken", 4'h4, C_IDLE, 13'h0C00, C_IDLE, C_IDLE);
    stat = 4'b0010;
    run_instr("bra_not", 4'h4, C_IDLE, 13'h0400, C_IDLE, C_IDLE);
    mm = 4'b1010; stat = 4'b1000;
    run_instr("brr_taken", 4'h5, C_IDLE, 13'h0E00, C_IDLE, C_IDLE);
    mm = 4'b0110; stat = 4'b1001;
    run_instr("brr_not", 4'h5, C_IDLE, 13'h0600, C_IDLE, C_IDLE);
    mm = 4'b0000; stat = 4'b1111;
    run_instr("bra_mm0", 4'h4, C_IDLE, 13'h0400, C_IDLE, C_IDLE);
  endtask

  task automatic test_mem();
    run_instr("store", 4'hC, C_RB, C_RB, 13'h0088, C_IDLE);
    run_instr("load", 4'h8, C_IDLE, C_IDLE, C_IDLE, 13'h0006);
  endtask

  task automatic test_nop();
    run_instr("nop0", 4'h0, C_IDLE, C_IDLE, C_IDLE, C_IDLE);
    run_instr("nop3", 4'h3, C_IDLE, C_IDLE, C_IDLE, C_IDLE);
    run_instr("nopE", 4'hE, C_IDLE, C_IDLE, C_IDLE, C_IDLE);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_ri", 4'h2, C_IDLE, 13'h0050, C_IDLE, 13'h0044);
    run_instr("b2b_st", 4'hC, C_RB, C_RB, 13'h0088, C_IDLE);
    run_instr("b2b_rr", 4'h1, C_IDLE, 13'h0030, C_IDLE, 13'h0024);
  endtask

  task automatic test_halt();
    int unsigned bad_cycles;
    opcode = 4'hF;
    n_cmp++;
    if (ctl !== C_FETCH) begin
      n_bad++;
      $display("FAIL halt_fetch: ctl got %h want %h", ctl, C_FETCH);
    end
    step();
    n_cmp++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL halt_decode: ctl got %h want %h", ctl, C_IDLE);
    end
    step();
    exp_icnt = exp_icnt + 16'd1;
    n_cmp++;
    if (ctl !== C_HALT || icount !== exp_icnt) begin
      n_bad++;
      $display("FAIL halt_enter: ctl got %h want %h, icount got %h want %h",
               ctl, C_HALT, icount, exp_icnt);
    end
    bad_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      opcode = 4'(i);
      step();
      if (ctl !== C_HALT || icount !== exp_icnt) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL halt_hold: %0d bad cycles of 100, last ctl %h want %h, icount %h want %h",
               bad_cycles, ctl, C_HALT, icount, exp_icnt);
    end
    do_reset("halt_reset");
  endtask

  task automatic test_reset_mid();
    opcode = 4'hC;
    step();
    step();
    step();
    n_cmp++;
    if (ctl !== 13'h0088) begin
      n_bad++;
      $display("FAIL midrst_mem: ctl got %h want %h", ctl, 13'h0088);
    end
    do_reset("midrst");
  endtask

  task automatic test_saturate();
    force dut.icount = 16'hFFFE;
    #1;
    release dut.icount;
    exp_icnt = 16'hFFFE;
    run_instr("sat_nop1", 4'h0, C_IDLE, C_IDLE, C_IDLE, C_IDLE);
    run_instr("sat_nop2", 4'h0, C_IDLE, C_IDLE, C_IDLE, C_IDLE);
    run_instr("sat_nop3", 4'h0, C_IDLE, C_IDLE, C_IDLE, C_IDLE);
    n_cmp++;
    if (icount !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_final: icount got %h want ffff", icount);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    exp_icnt = '0;
    rst_f    = 1'b0;
    opcode   = 4'h1;
    mm       = 4'h0;
    stat     = 4'h0;
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_nop();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
